// File: rtl/gray_serial_decoder.sv
// gray_serial_decoder
//   Receives framed Gray-coded nibbles on a strobed serial line and presents
//   the binary equivalent through a one-deep valid/ready output buffer.
//   Frame: start(0), g[3]..g[0], [even parity when PARITY_EN], stop(1).
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   sample_en     bit strobe; serial_in is only sampled when high
//   serial_in     serial line, idles high
//   out_ready     consumer accepts the buffered word
//   binary_output decoded word (held while out_valid and not consumed)
//   out_valid     binary_output holds an unconsumed word
//   parity_err    one-cycle pulse: parity failed with a good stop bit
//   frame_err     one-cycle pulse: stop bit sampled 0
//   overrun       one-cycle pulse: good word dropped, buffer full
module gray_serial_decoder #(
   parameter bit PARITY_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sample_en,
   input  logic       serial_in,
   input  logic       out_ready,
   output logic [3:0] binary_output,
   output logic       out_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       overrun
);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t     state, state_nx;
   logic [1:0] bit_cnt, bit_cnt_nx;
   logic [3:0] gray_sr, gray_sr_nx;
   logic       par_bit, par_bit_nx;
   logic [3:0] bin_dec;
   logic       word_good, perr_nx, ferr_nx;

   // Gray to binary: each binary bit folds in all higher Gray bits.
   always_comb begin
      bin_dec    = 4'b0000;
      bin_dec[3] = gray_sr[3];
      for (int i = 2; i >= 0; i--)
         bin_dec[i] = bin_dec[i+1] ^ gray_sr[i];
   end

   // Next-state logic; nothing advances without a strobe.
   always_comb begin
      state_nx   = state;
      bit_cnt_nx = bit_cnt;
      gray_sr_nx = gray_sr;
      par_bit_nx = par_bit;
      word_good  = 1'b0;
      perr_nx    = 1'b0;
      ferr_nx    = 1'b0;
      if (sample_en) begin
         case (state)
            IDLE: begin
               if (!serial_in) begin
                  state_nx   = DATA;
                  bit_cnt_nx = 2'd0;
               end
            end
            DATA: begin
               gray_sr_nx = {gray_sr[2:0], serial_in};
               bit_cnt_nx = bit_cnt + 2'd1;
               if (bit_cnt == 2'd3)
                  state_nx = PARITY_EN ? PARITY : STOP;
            end
            PARITY: begin
               par_bit_nx = serial_in;
               state_nx   = STOP;
            end
            STOP: begin
               state_nx = IDLE;
               // A bad stop bit masks any parity result for the frame.
               if (!serial_in)
                  ferr_nx = 1'b1;
               else if (PARITY_EN && ((^gray_sr) ^ par_bit))
                  perr_nx = 1'b1;
               else
                  word_good = 1'b1;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         bit_cnt <= 2'd0;
         gray_sr <= 4'd0;
         par_bit <= 1'b0;
      end else begin
         state   <= state_nx;
         bit_cnt <= bit_cnt_nx;
         gray_sr <= gray_sr_nx;
         par_bit <= par_bit_nx;
      end
   end

   // Output buffer: a same-edge transfer frees the slot for the new word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         binary_output <= 4'd0;
         out_valid     <= 1'b0;
         parity_err    <= 1'b0;
         frame_err     <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         parity_err <= perr_nx;
         frame_err  <= ferr_nx;
         overrun    <= 1'b0;
         if (word_good && (!out_valid || out_ready)) begin
            binary_output <= bin_dec;
            out_valid     <= 1'b1;
         end else begin
            if (word_good)
               overrun <= 1'b1;
            if (out_valid && out_ready)
               out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/gray_serial_decoder.md
GRAY_SERIAL_DECODER -- requirements
Module: gray_serial_decoder

Interface
REQ-001 Parameter PARITY_EN, default 1, meaning: 1 = frame carries an even-parity bit that is checked; 0 = no parity bit in the frame.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 sample_en  input  1  bit strobe; serial_in is sampled only on cycles where sample_en=1.
REQ-005 serial_in  input  1  serial line; idles high.
REQ-006 out_ready  input  1  consumer ready for a decoded word.
REQ-007 binary_output  output  4  decoded binary word.
REQ-008 out_valid  output  1  binary_output holds an unconsumed word.
REQ-009 parity_err  output  1  one-cycle pulse when a parity check fails.
REQ-010 frame_err  output  1  one-cycle pulse when the stop bit is 0.
REQ-011 overrun  output  1  one-cycle pulse when a good word is dropped because the buffer is full.

Function
REQ-012 Frame format, one bit per sample_en strobe, in this order: start bit (0); four Gray-coded data bits, g[3] first; parity bit (only when PARITY_EN=1), making the count of 1s over g[3:0] plus parity even; stop bit (1).
REQ-013 The FSM SHALL have the states IDLE, DATA, PARITY, STOP.
- IDLE->DATA on a strobe with serial_in=0.
- DATA holds for exactly four strobes, with a 2-bit counter.
- DATA then goes to PARITY, or directly to STOP when PARITY_EN=0.
- PARITY->STOP after one strobe.
- STOP->IDLE after one strobe.
REQ-014 No state, counter or shift register SHALL change on a cycle where sample_en=0.
REQ-015 Conversion from Gray to binary SHALL be b[3]=g[3] and b[i]=b[i+1]^g[i] for i=2..0.
REQ-016 A word is good when the STOP strobe samples 1 and parity passes (or PARITY_EN=0).
- On that clock edge, binary_output and out_valid SHALL update.
- Both are visible the cycle after the stop-bit strobe, so latency is 1 clk from the stop sample.
REQ-017 When the STOP strobe samples 0:
- frame_err SHALL pulse for one cycle, the word is discarded, and the FSM returns to IDLE.
- frame_err takes priority, so parity_err does not pulse for that frame.
REQ-018 When parity fails and the stop bit is 1, parity_err SHALL pulse for one cycle at the stop strobe and the word SHALL be discarded.
REQ-019 Handshake:
- A transfer occurs on a cycle where out_valid=1 and out_ready=1.
- out_valid SHALL clear on the next edge unless a new good word loads on the same edge.
REQ-020 Transfer and good-word load on the same edge: the new word SHALL load, out_valid SHALL stay 1, and there is no overrun.
REQ-021 Good word while out_valid=1 and out_ready=0:
- overrun SHALL pulse for one cycle.
- binary_output SHALL keep the old word, and the new word is dropped.
REQ-022 While out_valid=1 and no transfer occurs, binary_output SHALL hold stable.
REQ-023 Frame reception SHALL continue regardless of out_valid; the receiver never stalls the line.

Reset
REQ-024 On a clk edge with rst_n=0:
- the FSM SHALL go to IDLE and the bit counter and shift register to 0;
- binary_output SHALL be 4'b0000;
- out_valid, parity_err, frame_err and overrun SHALL be 0.
REQ-025 Reset mid-frame SHALL abandon the frame with no error pulse; the next 0 strobe after reset release starts a new frame.
REQ-026 During reset, sample_en and serial_in SHALL be ignored.

Verification
REQ-027 PARITY_EN=1, out_ready=1, frame 0,0110,0,1 -> binary_output=4'b0100 with out_valid=1 for one cycle, 1 clk after the stop strobe; no error pulses.
REQ-028 PARITY_EN=1, frame 0,1000,1,1 with out_ready=0 -> binary_output=4'b1111, out_valid held high.
- A second good frame 0,0001,1,1 -> overrun pulse, output stays 4'b1111.
- Then out_ready=1 -> out_valid clears next cycle.
REQ-029 Frame 0,0110,1,1 (bad parity) -> parity_err pulse, out_valid stays 0.
- Frame 0,0110,0,0 (bad stop) -> frame_err pulse only.
REQ-030 sample_en strobing every 4th cycle, with serial_in toggling between strobes -> decoded result identical to REQ-027.
REQ-031 rst_n=0 asserted after two data strobes, then the full frame 0,0011,0,1 -> no error pulses; binary_output=4'b0010.
REQ-032 PARITY_EN=0:
- Frame 0,1011,1 -> binary_output=4'b1101.
- out_ready asserted on the stop-strobe edge while a prior word is valid -> no overrun, out_valid stays 1 and holds the new word.
